lpif_tx_packer: RTL and testbench

LPIF_TX_PACKER -- requirements
Module: lpif_tx_packer

---
 rtl/lpif_tx_packer_if.sv | 44 ++++
 rtl/lpif_tx_packer.sv | 224 ++++++++++++++++++++++
 tb/tb_lpif_tx_packer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpif_tx_packer_if.sv
// ============================================================================
//  Module      : lpif_tx_packer_if
//  Description : Link-layer word input, LPIF beat output and error pulse
//                bundled for the TX packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lpif_tx_packer_if;
  // Link-layer word side
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_sop;
  logic         in_eop;
  logic         in_type;
  logic [2:0]   in_bytes;
  // LPIF beat side
  logic [511:0] lp_data;
  logic [63:0]  lp_valid;
  logic [63:0]  lp_tlpstart;
  logic [63:0]  lp_tlpend;
  logic [63:0]  lp_dlpstart;
  logic [63:0]  lp_dlpend;
  logic         lp_irdy;
  logic         pl_trdy;
  logic         err_pulse;

  // Word source / beat sink (link layer and TX-control side)
  modport master (
    output in_valid, in_data, in_sop, in_eop, in_type, in_bytes, pl_trdy,
    input  in_ready, lp_data, lp_valid, lp_tlpstart, lp_tlpend,
           lp_dlpstart, lp_dlpend, lp_irdy, err_pulse
  );

  // Packer
  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_type, in_bytes, pl_trdy,
    output in_ready, lp_data, lp_valid, lp_tlpstart, lp_tlpend,
           lp_dlpstart, lp_dlpend, lp_irdy, err_pulse
  );
endinterface

`default_nettype wire

// File: rtl/lpif_tx_packer.sv
// ============================================================================
//  Module      : lpif_tx_packer
//  Description : Packs 32-bit link-layer words into 512-bit LPIF beats of
//                sixteen 4-byte slots with per-byte valid and framing marks.
//                Partial beats are flushed after IDLE_FLUSH idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpif_tx_packer #(
  parameter int unsigned IDLE_FLUSH = 4
) (
  input  wire logic        pclk,
  input  wire logic        reset_n,
  lpif_tx_packer_if.slave  bus
);

  localparam logic [3:0] c_LAST_SLOT = 4'd15;
  localparam logic [7:0] c_FLUSH_AT  = 8'(IDLE_FLUSH - 1);

  // Accumulator (beat being built, or a completed beat waiting for the output)
  logic [511:0] acc_data_q,  acc_data_d;
  logic [63:0]  acc_valid_q, acc_valid_d;
  logic [63:0]  acc_ts_q,    acc_ts_d;
  logic [63:0]  acc_te_q,    acc_te_d;
  logic [63:0]  acc_ds_q,    acc_ds_d;
  logic [63:0]  acc_de_q,    acc_de_d;
  logic [3:0]   slot_q,      slot_d;
  logic [7:0]   idle_q,      idle_d;
  logic         done_q,      done_d;
  logic         pkt_q;
  logic         type_q;
  logic         in_ready_q;
  logic         err_q;

  // Output beat register
  logic [511:0] lp_data_q;
  logic [63:0]  lp_valid_q;
  logic [63:0]  lp_ts_q;
  logic [63:0]  lp_te_q;
  logic [63:0]  lp_ds_q;
  logic [63:0]  lp_de_q;
  logic         lp_irdy_q;

  // Word decode and merge results
  logic         w_accept;
  logic         w_viol;
  logic         w_good;
  logic         w_type;
  logic [1:0]   w_end_idx;
  logic [31:0]  w_slot_data;
  logic [3:0]   w_slot_valid;
  logic [3:0]   w_slot_start;
  logic [3:0]   w_slot_end;
  logic [511:0] w_m_data;
  logic [63:0]  w_m_valid;
  logic [63:0]  w_m_ts;
  logic [63:0]  w_m_te;
  logic [63:0]  w_m_ds;
  logic [63:0]  w_m_de;
  logic         w_nonempty;
  logic         w_full_word;
  logic         w_flush;
  logic         w_complete;
  logic         w_xfer;
  logic         w_load;

  // Word classification: dropped words still count as accepted (reset idle)
  assign w_accept  = bus.in_valid && in_ready_q;
  assign w_viol    = (bus.in_sop && pkt_q) || (!bus.in_sop && !pkt_q) ||
                     (!bus.in_eop && (bus.in_bytes != 3'd4));
  assign w_good    = w_accept && !w_viol;
  // The end mark uses the type latched at sop unless this word is its own sop
  assign w_type    = bus.in_sop ? bus.in_type : type_q;
  assign w_end_idx = bus.in_bytes[1:0] - 2'd1;

  assign w_nonempty  = (slot_q != 4'd0) && !done_q;
  assign w_full_word = w_good && (slot_q == c_LAST_SLOT);
  assign w_flush     = !w_accept && w_nonempty && (idle_q == c_FLUSH_AT);
  assign w_complete  = done_q || w_full_word || w_flush;
  assign w_xfer      = lp_irdy_q && !bus.pl_trdy;
  assign w_load      = w_complete && (!lp_irdy_q || w_xfer);

  // Build the slot image of the incoming word and merge it into the beat
  always_comb begin
    w_slot_data  = '0;
    w_slot_valid = '0;
    for (int j = 0; j < 4; j++) begin
      w_slot_valid[j]       = (3'(j) < bus.in_bytes);
      w_slot_data[8*j +: 8] = w_slot_valid[j] ? bus.in_data[8*j +: 8] : 8'h00;
    end
    w_slot_start = {3'b000, bus.in_sop};
    w_slot_end   = bus.in_eop ? (4'b0001 << w_end_idx) : 4'b0000;

    w_m_data  = acc_data_q;
    w_m_valid = acc_valid_q;
    w_m_ts    = acc_ts_q;
    w_m_te    = acc_te_q;
    w_m_ds    = acc_ds_q;
    w_m_de    = acc_de_q;
    if (w_good) begin
      w_m_data[{slot_q, 5'd0} +: 32] = w_slot_data;
      w_m_valid[{slot_q, 2'd0} +: 4] = w_slot_valid;
      w_m_ts[{slot_q, 2'd0} +: 4]    = w_type ? 4'b0000 : w_slot_start;
      w_m_te[{slot_q, 2'd0} +: 4]    = w_type ? 4'b0000 : w_slot_end;
      w_m_ds[{slot_q, 2'd0} +: 4]    = w_type ? w_slot_start : 4'b0000;
      w_m_de[{slot_q, 2'd0} +: 4]    = w_type ? w_slot_end : 4'b0000;
    end
  end

  // Next accumulator state: clear when the beat moves out, park it otherwise
  always_comb begin
    acc_data_d  = w_m_data;
    acc_valid_d = w_m_valid;
    acc_ts_d    = w_m_ts;
    acc_te_d    = w_m_te;
    acc_ds_d    = w_m_ds;
    acc_de_d    = w_m_de;
    slot_d      = slot_q;
    idle_d      = idle_q;
    done_d      = done_q;
    if (w_complete) begin
      slot_d = 4'd0;
      idle_d = 8'd0;
      if (w_load) begin
        acc_data_d  = '0;
        acc_valid_d = '0;
        acc_ts_d    = '0;
        acc_te_d    = '0;
        acc_ds_d    = '0;
        acc_de_d    = '0;
        done_d      = 1'b0;
      end else begin
        done_d = 1'b1;
      end
    end else begin
      if (w_good) begin
        slot_d = slot_q + 4'd1;
      end
      if (w_accept || !w_nonempty) begin
        idle_d = 8'd0;
      end else begin
        idle_d = idle_q + 8'd1;
      end
    end
  end

  // Accumulator, slot pointer, idle counter, packet tracking and handshake
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      acc_data_q  <= '0;
      acc_valid_q <= '0;
      acc_ts_q    <= '0;
      acc_te_q    <= '0;
      acc_ds_q    <= '0;
      acc_de_q    <= '0;
      slot_q      <= '0;
      idle_q      <= '0;
      done_q      <= 1'b0;
      pkt_q       <= 1'b0;
      type_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_valid_q <= acc_valid_d;
      acc_ts_q    <= acc_ts_d;
      acc_te_q    <= acc_te_d;
      acc_ds_q    <= acc_ds_d;
      acc_de_q    <= acc_de_d;
      slot_q      <= slot_d;
      idle_q      <= idle_d;
      done_q      <= done_d;
      in_ready_q  <= !done_d;
      err_q       <= w_accept && w_viol;
      if (w_good) begin
        if (bus.in_eop) begin
          pkt_q <= 1'b0;
        end else if (bus.in_sop) begin
          pkt_q <= 1'b1;
        end
        if (bus.in_sop) begin
          type_q <= bus.in_type;
        end
      end
    end
  end

  // Output beat register: loads a completed beat when free, holds under pl_trdy
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      lp_data_q  <= '0;
      lp_valid_q <= '0;
      lp_ts_q    <= '0;
      lp_te_q    <= '0;
      lp_ds_q    <= '0;
      lp_de_q    <= '0;
      lp_irdy_q  <= 1'b0;
    end else if (w_load) begin
      lp_data_q  <= w_m_data;
      lp_valid_q <= w_m_valid;
      lp_ts_q    <= w_m_ts;
      lp_te_q    <= w_m_te;
      lp_ds_q    <= w_m_ds;
      lp_de_q    <= w_m_de;
      lp_irdy_q  <= 1'b1;
    end else if (w_xfer) begin
      lp_irdy_q  <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.err_pulse   = err_q;
  assign bus.lp_data     = lp_data_q;
  assign bus.lp_valid    = lp_valid_q;
  assign bus.lp_tlpstart = lp_ts_q;
  assign bus.lp_tlpend   = lp_te_q;
  assign bus.lp_dlpstart = lp_ds_q;
  assign bus.lp_dlpend   = lp_de_q;
  assign bus.lp_irdy     = lp_irdy_q;

endmodule

`default_nettype wire

// File: tb/tb_lpif_tx_packer.sv
// ============================================================================
//  Module      : tb_lpif_tx_packer
//  Description : Self-checking bench for lpif_tx_packer. A reference packer
//                builds expected beats into a queue; a monitor pops and
//                compares each transferred beat.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lpif_tx_packer;

  localparam int unsigned IDLE_FLUSH = 4;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  valid;
    logic [63:0]  ts;
    logic [63:0]  te;
    logic [63:0]  ds;
    logic [63:0]  de;
  } beat_t;

  typedef struct {
    logic        sop;
    logic        eop;
    logic        typ;
    logic [2:0]  nb;
    logic [31:0] d;
    logic        exp_err;
  } vec_t;

  logic pclk    = 1'b0;
  logic reset_n = 1'b0;
  always #5 pclk = ~pclk;

  lpif_tx_packer_if bus ();

  lpif_tx_packer #(.IDLE_FLUSH(IDLE_FLUSH)) dut (
    .pclk    (pclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_beats = 0;
  int    irdy_cycles = 0;
  int    stalls = 0;
  beat_t sb[$];
  beat_t m_beat;
  int    m_slot = 0;
  logic  m_type = 1'b0;
  beat_t last_beat;
  beat_t mon_exp;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference packer
  task automatic model_clear();
    m_beat = '0;
    m_slot = 0;
  endtask

  task automatic model_push();
    sb.push_back(m_beat);
    model_clear();
  endtask

  task automatic model_flush();
    if (m_slot != 0) model_push();
  endtask

  task automatic model_word(input logic sop, input logic eop, input logic typ,
                            input logic [2:0] nb, input logic [31:0] d);
    int base;
    if (sop) m_type = typ;
    base = m_slot * 4;
    for (int j = 0; j < 4; j++) begin
      if (j < int'(nb)) begin
        m_beat.valid[base + j] = 1'b1;
        m_beat.data[(base + j) * 8 +: 8] = d[j * 8 +: 8];
      end
    end
    if (sop) begin
      if (m_type) m_beat.ds[base] = 1'b1;
      else        m_beat.ts[base] = 1'b1;
    end
    if (eop) begin
      if (m_type) m_beat.de[base + int'(nb) - 1] = 1'b1;
      else        m_beat.te[base + int'(nb) - 1] = 1'b1;
    end
    m_slot++;
    if (m_slot == 16) model_push();
  endtask

  // Present one word, wait (bounded) until it is accepted, check err_pulse
  task automatic send(input logic sop, input logic eop, input logic typ,
                      input logic [2:0] nb, input logic [31:0] d, input logic exp_err);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    bus.in_eop   = eop;
    bus.in_type  = typ;
    bus.in_bytes = nb;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(posedge pclk); #1;
      guard++;
    end
    if (guard > 0) stalls++;
    if (guard >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", guard);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge pclk); #1;
      bus.in_valid = 1'b0;
      check("err_pulse", bus.err_pulse, exp_err);
      if (!exp_err) model_word(sop, eop, typ, nb, d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  // Sixteen-word packet; bytes numbered from base so data is position-traceable
  task automatic send_pkt16(input logic typ, input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      send(i == 0, i == 15, typ, 3'd4,
           {8'(base + 8'(4*i+3)), 8'(base + 8'(4*i+2)), 8'(base + 8'(4*i+1)), 8'(base + 8'(4*i))},
           1'b0);
    end
  endtask

  // Monitor: every transfer pops one expected beat
  always @(negedge pclk) begin
    if (reset_n && bus.lp_irdy) irdy_cycles++;
    if (reset_n && bus.lp_irdy && !bus.pl_trdy) begin
      last_beat = {bus.lp_data, bus.lp_valid, bus.lp_tlpstart, bus.lp_tlpend,
                   bus.lp_dlpstart, bus.lp_dlpend};
      n_beats++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_unexpected: got beat valid=%0h, expected no beat", bus.lp_valid);
      end else begin
        mon_exp = sb.pop_front();
        check("beat_data",     bus.lp_data,     mon_exp.data);
        check("beat_valid",    bus.lp_valid,    mon_exp.valid);
        check("beat_tlpstart", bus.lp_tlpstart, mon_exp.ts);
        check("beat_tlpend",   bus.lp_tlpend,   mon_exp.te);
        check("beat_dlpstart", bus.lp_dlpstart, mon_exp.ds);
        check("beat_dlpend",   bus.lp_dlpend,   mon_exp.de);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[8];
  int   b0;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    bus.in_type  = 1'b0;
    bus.in_bytes = 3'd4;
    bus.in_data  = '0;
    bus.pl_trdy  = 1'b0;
    model_clear();

    // Single-word packets and protocol violations, applied as one stream
    vecs[0] = '{1'b1, 1'b1, 1'b0, 3'd4, 32'h1122_3344, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 3'd1, 32'hAABB_CCDD, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd4, 32'hDEAD_0002, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 3'd4, 32'h5566_7788, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 3'd3, 32'hDEAD_0004, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 3'd4, 32'hDEAD_0005, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 3'd3, 32'h99AA_BBCC, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h0102_0304, 1'b0};

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    check("rst_lp_irdy",   bus.lp_irdy,   1'b0);
    check("rst_lp_data",   bus.lp_data,   '0);
    check("rst_lp_valid",  bus.lp_valid,  '0);
    check("rst_marks",     bus.lp_tlpstart | bus.lp_tlpend | bus.lp_dlpstart | bus.lp_dlpend, '0);
    check("rst_err_pulse", bus.err_pulse, 1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b0);
    @(negedge pclk);
    reset_n = 1'b1;
    @(posedge pclk); #1;
    check("in_ready_after_release", bus.in_ready, 1'b1);

    // Full 16-word TLP beat, latency and single-cycle lp_irdy
    irdy_cycles = 0;
    b0 = n_beats;
    send_pkt16(1'b0, 8'd0);
    check("latency_irdy", bus.lp_irdy, 1'b1);
    idle(10);
    check_int("irdy_one_cycle", irdy_cycles, 1);
    check_int("full_beat_count", n_beats - b0, 1);
    check("full_valid",    last_beat.valid, {64{1'b1}});
    check("full_tlpstart", last_beat.ts, 64'h1);
    check("full_tlpend",   last_beat.te, 64'h8000_0000_0000_0000);
    check("full_byte63",   last_beat.data[511:504], 8'd63);

    // Two-word DLLP flushed after IDLE_FLUSH idle cycles
    send(1'b1, 1'b0, 1'b1, 3'd4, 32'h0403_0201, 1'b0);
    send(1'b0, 1'b1, 1'b0, 3'd2, 32'hFFFF_0605, 1'b0);
    model_flush();
    for (int i = 0; i < IDLE_FLUSH - 1; i++) begin
      idle(1);
      check("no_early_flush", bus.lp_irdy, 1'b0);
    end
    idle(1);
    check("flush_after_idle", bus.lp_irdy, 1'b1);
    idle(2);
    check("dllp_valid",    last_beat.valid, 64'h3F);
    check("dllp_dlpstart", last_beat.ds, 64'h1);
    check("dllp_dlpend",   last_beat.de, 64'h20);

    // Table-driven words
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].sop, vecs[i].eop, vecs[i].typ, vecs[i].nb, vecs[i].d, vecs[i].exp_err);
    end
    model_flush();
    idle(8);
    check_int("table_sb_drained", sb.size(), 0);

    // sop, data, sop: third word dropped, pointer stays at slot 2
    send(1'b1, 1'b0, 1'b0, 3'd4, 32'h1111_1111, 1'b0);
    send(1'b0, 1'b0, 1'b0, 3'd4, 32'h2222_2222, 1'b0);
    send(1'b1, 1'b0, 1'b0, 3'd4, 32'h3333_3333, 1'b1);
    idle(1);
    check("err_one_cycle", bus.err_pulse, 1'b0);
    send(1'b0, 1'b1, 1'b0, 3'd4, 32'h4444_4444, 1'b0);
    model_flush();
    idle(8);
    check("drop_valid", last_beat.valid, 64'hFFF);
    check("drop_tlpend", last_beat.te, 64'h800);

    // Word accepted exactly when the idle count would reach IDLE_FLUSH
    irdy_cycles = 0;
    send(1'b1, 1'b1, 1'b0, 3'd4, 32'hA1A2_A3A4, 1'b0);
    idle(IDLE_FLUSH - 1);
    send(1'b1, 1'b1, 1'b1, 3'd4, 32'hB1B2_B3B4, 1'b0);
    idle(IDLE_FLUSH - 1);
    check_int("no_flush_on_accept", irdy_cycles, 0);
    model_flush();
    idle(4);
    check("race_valid", last_beat.valid, 64'hFF);
    check("race_dlpstart", last_beat.ds, 64'h10);

    // Back-to-back throughput with no backpressure
    stalls = 0;
    b0 = n_beats;
    send_pkt16(1'b0, 8'd10);
    send_pkt16(1'b1, 8'd20);
    send_pkt16(1'b0, 8'd30);
    idle(4);
    check_int("b2b_no_stall", stalls, 0);
    check_int("b2b_beats", n_beats - b0, 3);

    // Backpressure: first beat held stable, second parked in accumulator
    bus.pl_trdy = 1'b1;
    b0 = n_beats;
    send_pkt16(1'b0, 8'd40);
    send_pkt16(1'b1, 8'd80);
    check("bp_in_ready_low", bus.in_ready, 1'b0);
    check_int("bp_two_pending", sb.size(), 2);
    idle(8);
    check("bp_hold_irdy",  bus.lp_irdy, 1'b1);
    check("bp_hold_data",  bus.lp_data, sb[0].data);
    check("bp_hold_valid", bus.lp_valid, sb[0].valid);
    check("bp_still_full", bus.in_ready, 1'b0);
    bus.pl_trdy = 1'b0;
    idle(4);
    check_int("bp_beats_out", n_beats - b0, 2);
    check("bp_ready_again", bus.in_ready, 1'b1);

    // Reset mid-beat with a beat held at the output
    bus.pl_trdy = 1'b1;
    send_pkt16(1'b0, 8'd100);
    for (int i = 0; i < 7; i++) begin
      send(i == 0, 1'b0, 1'b0, 3'd4, 32'hCAFE_0000 + i, 1'b0);
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_irdy",   bus.lp_irdy, 1'b0);
    check("mid_rst_valid",  bus.lp_valid, '0);
    check("mid_rst_data",   bus.lp_data, '0);
    check("mid_rst_marks",  bus.lp_tlpstart | bus.lp_tlpend | bus.lp_dlpstart | bus.lp_dlpend, '0);
    check("mid_rst_ready",  bus.in_ready, 1'b0);
    sb.delete();
    model_clear();
    m_type = 1'b0;
    bus.pl_trdy = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    reset_n = 1'b1;
    @(posedge pclk); #1;
    check("post_rst_ready", bus.in_ready, 1'b1);
    send(1'b1, 1'b0, 1'b0, 3'd4, 32'h0D0C_0B0A, 1'b0);
    send(1'b0, 1'b0, 1'b0, 3'd4, 32'h1D1C_1B1A, 1'b0);
    send(1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_002A, 1'b0);
    model_flush();
    idle(8);
    check("post_rst_valid", last_beat.valid, 64'h1FF);
    check("post_rst_tlpend", last_beat.te, 64'h100);

    check_int("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
